// File: rtl/work_queue_if.sv
// work_queue_if: scheduler/regfile bundle for work_queue (save/restore handshakes, register image in/out, occupancy)
interface work_queue_if #(parameter int AW = 3);
  logic save_req;
  logic [15:0] save_pc;
  logic [3:0] save_pred;
  logic save_ack;
  logic restore_req;
  logic restore_ack;
  logic [15:0] restore_pc;
  logic [3:0] restore_pred;
  logic give_me;
  logic [255:0] the_regs;
  logic writing_regs;
  logic [255:0] change_me;
  logic full;
  logic empty;
  logic [AW:0] count;
  modport master (
    output save_req, save_pc, save_pred, restore_req, the_regs,
    input save_ack, restore_ack, restore_pc, restore_pred, give_me, writing_regs, change_me, full, empty, count
  );
  modport slave (
    input save_req, save_pc, save_pred, restore_req, the_regs,
    output save_ack, restore_ack, restore_pc, restore_pred, give_me, writing_regs, change_me, full, empty, count
  );
endinterface

// File: rtl/work_queue.sv
// work_queue: FIFO of thread contexts (256b regs, 16b pc, 4b pred); ports clk, rst, bus (work_queue_if.slave)
module work_queue #(
  parameter int DEPTH = 8,
  parameter int AW = 3
) (
  input logic clk,
  input logic rst,
  work_queue_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SAVE_GIVE = 2'd1;
  localparam logic [1:0] SAVE_CAP = 2'd2;
  localparam logic [1:0] RESTORE = 2'd3;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  logic [1:0] state;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [15:0] pc_q, rpc;
  logic [3:0] pred_q, rpred;
  logic [255:0] chg;
  logic [275:0] mem [DEPTH];
  assign bus.save_ack = state == SAVE_CAP;
  assign bus.give_me = state == SAVE_GIVE;
  assign bus.restore_ack = state == RESTORE;
  assign bus.writing_regs = state == RESTORE;
  assign bus.restore_pc = rpc;
  assign bus.restore_pred = rpred;
  assign bus.change_me = chg;
  assign bus.count = count;
  assign bus.full = count == FULL_CNT;
  assign bus.empty = count == '0;
  always_ff @(posedge clk)
    if (!rst && state == SAVE_CAP) mem[wr_ptr] <= {bus.the_regs, pc_q, pred_q};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      pc_q <= '0;
      pred_q <= '0;
      rpc <= '0;
      rpred <= '0;
      chg <= '0;
    end else begin
      case (state)
        IDLE:
          if (bus.save_req && !bus.full) begin
            pc_q <= bus.save_pc;
            pred_q <= bus.save_pred;
            state <= SAVE_GIVE;
          end else if (bus.restore_req && !bus.empty) begin
            {chg, rpc, rpred} <= mem[rd_ptr];
            state <= RESTORE;
          end
        SAVE_GIVE: state <= SAVE_CAP;
        SAVE_CAP: begin
          wr_ptr <= wr_ptr + AW'(1);
          count <= count + (AW + 1)'(1);
          state <= IDLE;
        end
        default: begin
          rd_ptr <= rd_ptr + AW'(1);
          count <= count - (AW + 1)'(1);
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_work_queue.sv
// tb_work_queue: directed self-checking bench for work_queue
module tb_work_queue;
  logic clk = 0;
  logic rst;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  work_queue_if #(.AW(3)) bus();
  work_queue #(.DEPTH(8), .AW(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  function automatic logic [255:0] img(input logic [15:0] base);
    logic [255:0] r;
    for (int i = 0; i < 16; i++) r[16*i +: 16] = base + 16'(i);
    return r;
  endfunction
  function automatic logic [15:0] base_of(input logic [15:0] pc);
    return 16'h2000 + {pc[11:0], 4'h0};
  endfunction
  task automatic save_op(input logic [15:0] pc, input logic [3:0] pred, input logic [255:0] regs, output int lat);
    bus.save_pc = pc;
    bus.save_pred = pred;
    bus.the_regs = regs;
    bus.save_req = 1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.save_ack) begin
        lat = i;
        break;
      end
    end
    bus.save_req = 0;
    @(posedge clk); #1;
  endtask
  task automatic restore_op(output int lat, output logic [15:0] pc, output logic [3:0] pred,
                            output logic [255:0] regs, output logic wr);
    bus.restore_req = 1;
    lat = -1;
    pc = 'x;
    pred = 'x;
    regs = 'x;
    wr = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.restore_ack) begin
        lat = i;
        pc = bus.restore_pc;
        pred = bus.restore_pred;
        regs = bus.change_me;
        wr = bus.writing_regs;
        break;
      end
    end
    bus.restore_req = 0;
    @(posedge clk); #1;
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    total++;
    if ({bus.count, bus.empty, bus.full, bus.give_me, bus.save_ack, bus.restore_ack, bus.writing_regs} !== 10'b0000_1_0_0000) begin
      bad++;
      $display("FAIL reset_flags got count=%0d empty=%b full=%b gm=%b sa=%b ra=%b wr=%b want count=0 empty=1 rest 0",
               bus.count, bus.empty, bus.full, bus.give_me, bus.save_ack, bus.restore_ack, bus.writing_regs);
    end
    total++;
    if (bus.restore_pc !== 16'h0 || bus.restore_pred !== 4'h0 || bus.change_me !== 256'h0) begin
      bad++;
      $display("FAIL reset_data got pc=%h pred=%h want 0", bus.restore_pc, bus.restore_pred);
    end
  endtask
  task automatic test_save_basic;
    bus.save_pc = 16'h0010;
    bus.save_pred = 4'h5;
    bus.the_regs = img(16'h1100);
    bus.save_req = 1;
    @(posedge clk); #1;
    total++;
    if (bus.give_me !== 1 || bus.save_ack !== 0) begin
      bad++;
      $display("FAIL save1_give got gm=%b ack=%b want gm=1 ack=0", bus.give_me, bus.save_ack);
    end
    @(posedge clk); #1;
    total++;
    if (bus.give_me !== 0 || bus.save_ack !== 1) begin
      bad++;
      $display("FAIL save1_ack got gm=%b ack=%b want gm=0 ack=1", bus.give_me, bus.save_ack);
    end
    bus.save_req = 0;
    @(posedge clk); #1;
    total++;
    if (bus.save_ack !== 0 || bus.count !== 4'd1 || bus.empty !== 0) begin
      bad++;
      $display("FAIL save1_after got ack=%b count=%0d empty=%b want ack=0 count=1 empty=0", bus.save_ack, bus.count, bus.empty);
    end
  endtask
  task automatic test_restore_basic;
    int lat;
    logic [15:0] pc;
    logic [3:0] pred;
    logic [255:0] regs;
    logic wr;
    restore_op(lat, pc, pred, regs, wr);
    total++;
    if (lat !== 1 || wr !== 1) begin
      bad++;
      $display("FAIL restore1_lat got lat=%0d wr=%b want lat=1 wr=1", lat, wr);
    end
    total++;
    if (pc !== 16'h0010 || pred !== 4'h5 || regs[255:240] !== 16'h110F || regs[15:0] !== 16'h1100) begin
      bad++;
      $display("FAIL restore1_data got pc=%h pred=%h r15=%h r0=%h want 0010 5 110f 1100", pc, pred, regs[255:240], regs[15:0]);
    end
    total++;
    if (bus.count !== 4'd0 || bus.empty !== 1 || bus.restore_ack !== 0 || bus.writing_regs !== 0 || bus.restore_pc !== 16'h0010) begin
      bad++;
      $display("FAIL restore1_after got count=%0d empty=%b ack=%b wr=%b pc=%h want 0 1 0 0 0010",
               bus.count, bus.empty, bus.restore_ack, bus.writing_regs, bus.restore_pc);
    end
  endtask
  task automatic test_full_wrap;
    int lat;
    logic [15:0] pc;
    logic [3:0] pred;
    logic [255:0] regs;
    logic wr;
    for (int k = 0; k < 8; k++) begin
      save_op(16'(k), 4'(k), img(base_of(16'(k))), lat);
      total++;
      if (lat !== 2) begin
        bad++;
        $display("FAIL fill_lat[%0d] got %0d want 2", k, lat);
      end
    end
    total++;
    if (bus.full !== 1 || bus.count !== 4'd8) begin
      bad++;
      $display("FAIL fill_full got full=%b count=%0d want 1 8", bus.full, bus.count);
    end
    bus.save_pc = 16'h00FF;
    bus.save_req = 1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      total++;
      if (bus.give_me !== 0 || bus.save_ack !== 0) begin
        bad++;
        $display("FAIL full_hold[%0d] got gm=%b ack=%b want 0 0", c, bus.give_me, bus.save_ack);
      end
    end
    bus.save_req = 0;
    total++;
    if (bus.count !== 4'd8) begin
      bad++;
      $display("FAIL full_count got %0d want 8", bus.count);
    end
    for (int k = 0; k < 8; k++) begin
      restore_op(lat, pc, pred, regs, wr);
      total++;
      if (lat !== 1 || pc !== 16'(k) || pred !== 4'(k) || regs[15:0] !== base_of(16'(k))) begin
        bad++;
        $display("FAIL drain[%0d] got lat=%0d pc=%h pred=%h r0=%h want 1 %h %h %h", k, lat, pc, pred, regs[15:0], 16'(k), 4'(k), base_of(16'(k)));
      end
    end
    total++;
    if (bus.empty !== 1 || bus.full !== 0) begin
      bad++;
      $display("FAIL drain_empty got empty=%b full=%b want 1 0", bus.empty, bus.full);
    end
    for (int k = 0; k < 4; k++) begin
      save_op(16'h0100 + 16'(k), 4'hA, img(base_of(16'h0100 + 16'(k))), lat);
      restore_op(lat, pc, pred, regs, wr);
      total++;
      if (pc !== 16'h0100 + 16'(k) || pred !== 4'hA || regs[255:240] !== base_of(16'h0100 + 16'(k)) + 16'hF) begin
        bad++;
        $display("FAIL wrap[%0d] got pc=%h pred=%h r15=%h want %h a %h", k, pc, pred, regs[255:240],
                 16'h0100 + 16'(k), base_of(16'h0100 + 16'(k)) + 16'hF);
      end
    end
  endtask
  task automatic test_empty_restore;
    bus.restore_req = 1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++;
      if (bus.restore_ack !== 0 || bus.writing_regs !== 0) begin
        bad++;
        $display("FAIL empty_hold[%0d] got ack=%b wr=%b want 0 0", c, bus.restore_ack, bus.writing_regs);
      end
    end
    bus.save_pc = 16'h0777;
    bus.save_pred = 4'h3;
    bus.the_regs = img(base_of(16'h0777));
    bus.save_req = 1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      if (e == 2) begin
        total++;
        if (bus.save_ack !== 1 || bus.restore_ack !== 0) begin
          bad++;
          $display("FAIL empty_then_save got sa=%b ra=%b want 1 0", bus.save_ack, bus.restore_ack);
        end
        bus.save_req = 0;
      end
    end
    total++;
    if (bus.restore_ack !== 1 || bus.restore_pc !== 16'h0777 || bus.restore_pred !== 4'h3) begin
      bad++;
      $display("FAIL empty_then_restore got ra=%b pc=%h pred=%h want 1 0777 3", bus.restore_ack, bus.restore_pc, bus.restore_pred);
    end
    bus.restore_req = 0;
    @(posedge clk); #1;
  endtask
  task automatic test_priority;
    int lat;
    logic [15:0] pc;
    logic [3:0] pred;
    logic [255:0] regs;
    logic wr;
    save_op(16'h00A0, 4'h1, img(base_of(16'h00A0)), lat);
    save_op(16'h00A1, 4'h2, img(base_of(16'h00A1)), lat);
    bus.save_pc = 16'h00A2;
    bus.save_pred = 4'h4;
    bus.the_regs = img(base_of(16'h00A2));
    bus.save_req = 1;
    bus.restore_req = 1;
    @(posedge clk); #1;
    total++;
    if (bus.give_me !== 1 || bus.writing_regs !== 0) begin
      bad++;
      $display("FAIL prio_first got gm=%b wr=%b want 1 0", bus.give_me, bus.writing_regs);
    end
    @(posedge clk); #1;
    bus.save_req = 0;
    @(posedge clk); #1;
    total++;
    if (bus.count !== 4'd3 || bus.restore_ack !== 0) begin
      bad++;
      $display("FAIL prio_count got count=%0d ra=%b want 3 0", bus.count, bus.restore_ack);
    end
    @(posedge clk); #1;
    total++;
    if (bus.restore_ack !== 1 || bus.restore_pc !== 16'h00A0 || bus.restore_pred !== 4'h1) begin
      bad++;
      $display("FAIL prio_restore got ra=%b pc=%h pred=%h want 1 00a0 1", bus.restore_ack, bus.restore_pc, bus.restore_pred);
    end
    bus.restore_req = 0;
    @(posedge clk); #1;
    restore_op(lat, pc, pred, regs, wr);
    restore_op(lat, pc, pred, regs, wr);
    total++;
    if (pc !== 16'h00A2 || bus.empty !== 1) begin
      bad++;
      $display("FAIL prio_drain got pc=%h empty=%b want 00a2 1", pc, bus.empty);
    end
  endtask
  task automatic test_reset_mid_save;
    int lat;
    logic [15:0] pc;
    logic [3:0] pred;
    logic [255:0] regs;
    logic wr;
    for (int k = 0; k < 4; k++) save_op(16'h0300 + 16'(k), 4'h6, img(base_of(16'h0300)), lat);
    bus.save_pc = 16'h03FF;
    bus.save_req = 1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.count !== 4'd4 || bus.give_me !== 0) begin
      bad++;
      $display("FAIL rst_pre got count=%0d gm=%b want 4 0", bus.count, bus.give_me);
    end
    rst = 1;
    bus.save_req = 0;
    @(posedge clk); #1;
    rst = 0;
    total++;
    if (bus.count !== 4'd0 || bus.empty !== 1 || bus.give_me !== 0 || bus.writing_regs !== 0 || bus.save_ack !== 0) begin
      bad++;
      $display("FAIL rst_mid got count=%0d empty=%b gm=%b wr=%b sa=%b want 0 1 0 0 0",
               bus.count, bus.empty, bus.give_me, bus.writing_regs, bus.save_ack);
    end
    save_op(16'h0444, 4'h9, img(base_of(16'h0444)), lat);
    restore_op(lat, pc, pred, regs, wr);
    total++;
    if (pc !== 16'h0444 || pred !== 4'h9 || bus.empty !== 1) begin
      bad++;
      $display("FAIL rst_recover got pc=%h pred=%h empty=%b want 0444 9 1", pc, pred, bus.empty);
    end
  endtask
  initial begin
    bus.save_req = 0;
    bus.restore_req = 0;
    bus.save_pc = 0;
    bus.save_pred = 0;
    bus.the_regs = 0;
    test_reset;
    test_save_basic;
    test_restore_basic;
    test_full_wrap;
    test_empty_restore;
    test_priority;
    test_reset_mid_save;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
